// File: rtl/microwave_timer_ctrl.sv
// Microwave mm:ss countdown sequencer: keypad entry, once-per-second decrement, magnetron enable.
// Latency: one cycle from any input to its effect; done pulses on the edge that reaches 0:00.
module microwave_timer_ctrl #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_open,
  output logic [3:0] min_bcd,
  output logic [3:0] dseg_bcd,
  output logic [3:0] seg_bcd,
  output logic [1:0] state_o,
  output logic       magnetron_on,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICKS_PER_SEC - 1);

  state_t        state_q, state_d;
  logic [3:0]    min_q, min_d;
  logic [3:0]    dseg_q, dseg_d;
  logic [3:0]    seg_q, seg_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;

  logic [3:0] dec_min, dec_dseg, dec_seg;
  logic       dec_zero, time_zero, start_ok, tick;

  // Borrow chain; guarded so the time never wraps below 0:00.
  always_comb begin
    dec_min  = min_q;
    dec_dseg = dseg_q;
    dec_seg  = seg_q;
    if (seg_q != 4'd0) begin
      dec_seg = seg_q - 4'd1;
    end else if (dseg_q != 4'd0) begin
      dec_dseg = dseg_q - 4'd1;
      dec_seg  = 4'd9;
    end else if (min_q != 4'd0) begin
      dec_min  = min_q - 4'd1;
      dec_dseg = 4'd5;
      dec_seg  = 4'd9;
    end
  end

  assign dec_zero  = (dec_min == 4'd0) && (dec_dseg == 4'd0) && (dec_seg == 4'd0);
  assign time_zero = (min_q == 4'd0) && (dseg_q == 4'd0) && (seg_q == 4'd0);
  assign start_ok  = !time_zero && (dseg_q <= 4'd5);
  assign tick      = (presc_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    dseg_d  = dseg_q;
    seg_d   = seg_q;
    presc_d = '0;
    done_d  = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      min_d   = 4'd0;
      dseg_d  = 4'd0;
      seg_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (door_open || stop) begin
            state_d = S_IDLE;
          end else if (start) begin
            if (start_ok) state_d = S_RUN;
          end else if (key_valid && (key_digit <= 4'd9)) begin
            min_d  = dseg_q;
            dseg_d = seg_q;
            seg_d  = key_digit;
          end
        end
        S_RUN: begin
          if (door_open || stop) begin
            state_d = S_PAUSE;
          end else if (tick) begin
            min_d  = dec_min;
            dseg_d = dec_dseg;
            seg_d  = dec_seg;
            if (dec_zero) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_PAUSE: begin
          if (door_open) begin
            state_d = S_PAUSE;
          end else if (stop) begin
            state_d = S_IDLE;
            min_d   = 4'd0;
            dseg_d  = 4'd0;
            seg_d   = 4'd0;
          end else if (start) begin
            state_d = S_RUN;
          end
        end
        default: begin
          min_d  = 4'd0;
          dseg_d = 4'd0;
          seg_d  = 4'd0;
          if (stop || start || key_valid) state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      min_q   <= 4'd0;
      dseg_q  <= 4'd0;
      seg_q   <= 4'd0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      dseg_q  <= dseg_d;
      seg_q   <= seg_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign min_bcd      = min_q;
  assign dseg_bcd     = dseg_q;
  assign seg_bcd      = seg_q;
  assign state_o      = state_q;
  assign magnetron_on = (state_q == S_RUN);
  assign done         = done_q;

endmodule
